// File: rtl/hack_ctrl_pkg.sv
// Purpose : shared types and Hack instruction field positions for the control sequencer.
// Latency : n/a (definitions only).
// Backpr. : n/a.
// Contents: state_e (2-bit FSM encoding), IR bit/field positions.
package hack_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_MEMRD  = 2'd2,
      ST_EXEC   = 2'd3
   } state_e;

   // Instruction field positions
   localparam int IS_C    = 15;  // 1 = C-instruction
   localparam int A_BIT   = 12;  // y operand from M instead of A
   localparam int COMP_HI = 11;  // comp = {zx,nx,zy,ny,f,no}
   localparam int COMP_LO = 6;
   localparam int DEST_A  = 5;   // dest bits d1..d3
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int JUMP_HI = 2;   // jump bits j1..j3
   localparam int JUMP_LO = 0;

endpackage

// File: rtl/hack_ctrl_if.sv
// Purpose : bundles the sequencer's memory handshakes, ALU flags and datapath strobes.
// Latency : n/a (wiring only).
// Backpr. : requests are held by the master until the matching ack.
// Ports   : master = control sequencer (drives requests/strobes), slave = datapath + memories.
interface hack_ctrl_if;

   logic        imem_req;
   logic        imem_ack;
   logic [15:0] instr;
   logic        dmem_rd_req;
   logic        dmem_wr_req;
   logic        dmem_ack;
   logic        zr;
   logic        nr;
   logic [5:0]  alu_ctl;
   logic        y_sel_m;
   logic        a_src_ir;
   logic        load_a;
   logic        load_d;
   logic        mdr_load;
   logic        pc_load;
   logic        pc_inc;
   logic [15:0] ir;
   logic        retire;

   modport master (
      output imem_req, dmem_rd_req, dmem_wr_req, alu_ctl, y_sel_m, a_src_ir,
             load_a, load_d, mdr_load, pc_load, pc_inc, ir, retire,
      input  imem_ack, instr, dmem_ack, zr, nr
   );

   modport slave (
      input  imem_req, dmem_rd_req, dmem_wr_req, alu_ctl, y_sel_m, a_src_ir,
             load_a, load_d, mdr_load, pc_load, pc_inc, ir, retire,
      output imem_ack, instr, dmem_ack, zr, nr
   );

endinterface

// File: rtl/hack_ctrl_jump_eval.sv
// Purpose : evaluates the Hack jump condition from the jump bits and ALU flags.
// Latency : combinational, 0 cycles.
// Backpr. : none.
// Ports   : jmp[2:0] = {j1,j2,j3}, zr/nr = ALU flags, take = branch to A.
module jump_eval (
   input  logic [2:0] jmp,
   input  logic       zr,
   input  logic       nr,
   output logic       take
);

   // j1 = less than zero, j2 = equal to zero, j3 = greater than zero
   assign take = (jmp[2] & nr) | (jmp[1] & zr) | (jmp[0] & ~nr & ~zr);

endmodule

// File: rtl/hack_ctrl.sv
// Purpose : multi-cycle FETCH/DECODE/MEMRD/EXEC control sequencer for the Hack CPU datapath.
// Latency : A-instr 2 cycles, C-instr 3 cycles, +1 for an M read, +1 per ack wait cycle.
// Backpr. : imem/dmem requests are held from state until ack; ack accepted in the request cycle.
// Ports   : clk, reset (sync, active-high, forces all outputs low); bus = hack_ctrl_if.master.
module hack_ctrl
   import hack_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   hack_ctrl_if.master  bus
);

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        take;
   logic        exec_done;

   logic        imem_req_c, dmem_rd_req_c, dmem_wr_req_c;
   logic [5:0]  alu_ctl_c;
   logic        y_sel_m_c, a_src_ir_c, load_a_c, load_d_c, mdr_load_c;
   logic        pc_load_c, pc_inc_c, retire_c;

   jump_eval u_jump_eval (
      .jmp  (ir_q[JUMP_HI:JUMP_LO]),
      .zr   (bus.zr),
      .nr   (bus.nr),
      .take (take)
   );

   // Without an M write the commit is immediate; with one it waits for the write ack.
   assign exec_done = (state_q == ST_EXEC) & (~ir_q[DEST_M] | bus.dmem_ack);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         ST_FETCH: begin
            if (bus.imem_ack) begin
               ir_d    = bus.instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!ir_q[IS_C])      state_d = ST_FETCH;
            else if (ir_q[A_BIT]) state_d = ST_MEMRD;
            else                  state_d = ST_EXEC;
         end
         ST_MEMRD: begin
            if (bus.dmem_ack) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (exec_done) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Outputs
   always_comb begin
      imem_req_c    = 1'b0;
      dmem_rd_req_c = 1'b0;
      dmem_wr_req_c = 1'b0;
      alu_ctl_c     = '0;
      y_sel_m_c     = 1'b0;
      a_src_ir_c    = 1'b0;
      load_a_c      = 1'b0;
      load_d_c      = 1'b0;
      mdr_load_c    = 1'b0;
      pc_load_c     = 1'b0;
      pc_inc_c      = 1'b0;
      retire_c      = 1'b0;
      case (state_q)
         ST_FETCH: imem_req_c = 1'b1;
         ST_DECODE: begin
            // A-instructions retire here; C-instructions are silent in decode.
            if (!ir_q[IS_C]) begin
               load_a_c   = 1'b1;
               a_src_ir_c = 1'b1;
               pc_inc_c   = 1'b1;
               retire_c   = 1'b1;
            end
         end
         ST_MEMRD: begin
            dmem_rd_req_c = 1'b1;
            mdr_load_c    = bus.dmem_ack;
         end
         ST_EXEC: begin
            // ALU controls held for the whole state so the write data stays stable.
            alu_ctl_c     = ir_q[COMP_HI:COMP_LO];
            y_sel_m_c     = ir_q[A_BIT];
            dmem_wr_req_c = ir_q[DEST_M];
            if (exec_done) begin
               load_a_c  = ir_q[DEST_A];
               load_d_c  = ir_q[DEST_D];
               retire_c  = 1'b1;
               pc_load_c = take;
               pc_inc_c  = ~take;
            end
         end
         default: ;
      endcase
   end

   // Reset forces every output low, including the same-cycle combinational strobes.
   assign bus.imem_req    = ~reset & imem_req_c;
   assign bus.dmem_rd_req = ~reset & dmem_rd_req_c;
   assign bus.dmem_wr_req = ~reset & dmem_wr_req_c;
   assign bus.alu_ctl     = {6{~reset}} & alu_ctl_c;
   assign bus.y_sel_m     = ~reset & y_sel_m_c;
   assign bus.a_src_ir    = ~reset & a_src_ir_c;
   assign bus.load_a      = ~reset & load_a_c;
   assign bus.load_d      = ~reset & load_d_c;
   assign bus.mdr_load    = ~reset & mdr_load_c;
   assign bus.pc_load     = ~reset & pc_load_c;
   assign bus.pc_inc      = ~reset & pc_inc_c;
   assign bus.retire      = ~reset & retire_c;
   assign bus.ir          = {16{~reset}} & ir_q;

endmodule

// File: tb/tb_hack_ctrl.sv
// Purpose : directed self-checking bench for hack_ctrl.
// Latency : n/a.
// Backpr. : acks driven by the bench with fixed wait counts.
module tb_hack_ctrl;
   import hack_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   hack_ctrl_if bus ();

   hack_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One zero-wait fetch from FETCH; leaves the DUT in DECODE.
   task automatic fetch(input logic [15:0] w);
      bus.imem_ack = 1'b1;
      bus.instr    = w;
      #2;
      chk_eq("fetch_imem_req", 32'(bus.imem_req), 32'd1);
      tick();
      bus.imem_ack = 1'b0;
   endtask

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      reset        = 1'b1;
      bus.imem_ack = 1'b0;
      bus.instr    = 16'h0000;
      bus.dmem_ack = 1'b0;
      bus.zr       = 1'b0;
      bus.nr       = 1'b0;
      tick();
      tick();
      #2;
      chk_eq("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk_eq("rst_ir",       32'(bus.ir),       32'd0);
      chk_eq("rst_retire",   32'(bus.retire),   32'd0);
      tick();
      reset = 1'b0;

      // A-instruction @21
      fetch(16'h0015);
      #2;
      chk_eq("a_ir",       32'(bus.ir),       32'h0015);
      chk_eq("a_load_a",   32'(bus.load_a),   32'd1);
      chk_eq("a_src_ir",   32'(bus.a_src_ir), 32'd1);
      chk_eq("a_pc_inc",   32'(bus.pc_inc),   32'd1);
      chk_eq("a_pc_load",  32'(bus.pc_load),  32'd0);
      chk_eq("a_retire",   32'(bus.retire),   32'd1);
      tick();
      #2;
      chk_eq("a_next_fetch", 32'(bus.imem_req), 32'd1);
      tick();

      // D=A; a stray imem_ack during DECODE must not reload IR
      fetch(16'hEC10);
      bus.imem_ack = 1'b1;
      bus.instr    = 16'h1234;
      #2;
      chk_eq("dec_c_retire", 32'(bus.retire),      32'd0);
      chk_eq("dec_c_load_a", 32'(bus.load_a),      32'd0);
      chk_eq("dec_c_rd",     32'(bus.dmem_rd_req), 32'd0);
      tick();
      bus.imem_ack = 1'b0;
      #2;
      chk_eq("dea_alu_ctl", 32'(bus.alu_ctl),     32'b110000);
      chk_eq("dea_y_sel_m", 32'(bus.y_sel_m),     32'd0);
      chk_eq("dea_load_d",  32'(bus.load_d),      32'd1);
      chk_eq("dea_load_a",  32'(bus.load_a),      32'd0);
      chk_eq("dea_pc_inc",  32'(bus.pc_inc),      32'd1);
      chk_eq("dea_rd",      32'(bus.dmem_rd_req), 32'd0);
      chk_eq("dea_wr",      32'(bus.dmem_wr_req), 32'd0);
      chk_eq("dea_retire",  32'(bus.retire),      32'd1);
      chk_eq("dea_ir_kept", 32'(bus.ir),          32'hEC10);
      tick();
      #2;
      chk_eq("dea_next_fetch", 32'(bus.imem_req), 32'd1);
      tick();

      // D=M with read ack after 2 wait cycles
      fetch(16'hFC10);
      #2;
      chk_eq("dem_dec_rd", 32'(bus.dmem_rd_req), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.dmem_ack = (i == 2);
         #2;
         chk_eq("dem_rd_req",   32'(bus.dmem_rd_req), 32'd1);
         chk_eq("dem_mdr_load", 32'(bus.mdr_load),    (i == 2) ? 32'd1 : 32'd0);
         chk_eq("dem_no_retire", 32'(bus.retire),     32'd0);
         tick();
      end
      bus.dmem_ack = 1'b0;
      #2;
      chk_eq("dem_y_sel_m", 32'(bus.y_sel_m),     32'd1);
      chk_eq("dem_load_d",  32'(bus.load_d),      32'd1);
      chk_eq("dem_alu_ctl", 32'(bus.alu_ctl),     32'b110000);
      chk_eq("dem_rd_off",  32'(bus.dmem_rd_req), 32'd0);
      chk_eq("dem_retire",  32'(bus.retire),      32'd1);
      tick();

      // M=D+1 with write ack after 3 wait cycles
      fetch(16'hE7C8);
      tick();
      for (int i = 0; i < 4; i++) begin
         bus.dmem_ack = (i == 3);
         #2;
         chk_eq("mw_wr_req",  32'(bus.dmem_wr_req), 32'd1);
         chk_eq("mw_alu_ctl", 32'(bus.alu_ctl),     32'b011111);
         chk_eq("mw_retire",  32'(bus.retire),      (i == 3) ? 32'd1 : 32'd0);
         chk_eq("mw_pc_inc",  32'(bus.pc_inc),      (i == 3) ? 32'd1 : 32'd0);
         chk_eq("mw_load_d",  32'(bus.load_d),      32'd0);
         tick();
      end
      bus.dmem_ack = 1'b0;
      #2;
      chk_eq("mw_next_fetch", 32'(bus.imem_req), 32'd1);

      // D;JGT with positive D
      fetch(16'hE301);
      tick();
      bus.zr = 1'b0;
      bus.nr = 1'b0;
      #2;
      chk_eq("jgt_pos_pc_load", 32'(bus.pc_load), 32'd1);
      chk_eq("jgt_pos_pc_inc",  32'(bus.pc_inc),  32'd0);
      chk_eq("jgt_pos_retire",  32'(bus.retire),  32'd1);
      tick();

      // D;JGT with zero D
      fetch(16'hE301);
      tick();
      bus.zr = 1'b1;
      #2;
      chk_eq("jgt_zero_pc_load", 32'(bus.pc_load), 32'd0);
      chk_eq("jgt_zero_pc_inc",  32'(bus.pc_inc),  32'd1);
      tick();
      bus.zr = 1'b0;

      // 0;JMP under negative and zero flags
      fetch(16'hEA87);
      tick();
      bus.nr = 1'b1;
      #2;
      chk_eq("jmp_neg_pc_load", 32'(bus.pc_load), 32'd1);
      chk_eq("jmp_alu_ctl",     32'(bus.alu_ctl), 32'b101010);
      tick();
      bus.nr = 1'b0;
      fetch(16'hEA87);
      tick();
      bus.zr = 1'b1;
      #2;
      chk_eq("jmp_zero_pc_load", 32'(bus.pc_load), 32'd1);
      chk_eq("jmp_zero_pc_inc",  32'(bus.pc_inc),  32'd0);
      tick();
      bus.zr = 1'b0;

      // Reset while waiting in MEMRD, with an ack arriving in the reset cycle
      fetch(16'hFC10);
      tick();
      #2;
      chk_eq("rmr_rd_before", 32'(bus.dmem_rd_req), 32'd1);
      reset        = 1'b1;
      bus.dmem_ack = 1'b1;
      #1;
      chk_eq("rmr_rd_drop",   32'(bus.dmem_rd_req), 32'd0);
      chk_eq("rmr_mdr_load",  32'(bus.mdr_load),    32'd0);
      chk_eq("rmr_retire",    32'(bus.retire),      32'd0);
      chk_eq("rmr_imem_req",  32'(bus.imem_req),    32'd0);
      tick();
      reset        = 1'b0;
      bus.dmem_ack = 1'b0;
      #2;
      chk_eq("rmr_state", 32'(dut.state_q), 32'(ST_FETCH));
      chk_eq("rmr_ir",    32'(bus.ir),       32'd0);
      chk_eq("rmr_imem_req_after", 32'(bus.imem_req), 32'd1);
      chk_eq("rmr_rd_after", 32'(bus.dmem_rd_req), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
